// File: rtl/seq_detector_param.sv
// Configurable serial pattern detector with overlap/non-overlap modes and runtime reconfiguration.
// Optional saturating match counter is enabled by defining SEQDET_COUNT_EN.
//
// state | meaning
// IDLE  | no valid configuration, input bits ignored
// FILL  | configured, history holds fewer than len bits
// RUN   | history full, every accepted bit is compared
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 16,
  localparam int LEN_W = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               detected,
  output logic               cfg_err,
  output logic               armed
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic               ovl;

  logic               cfg_ok;
  logic               take;
  logic               hit;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_nxt;

  always_comb begin
    cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    take     = in_valid && (state != IDLE);
    hist_nxt = {hist[MAX_LEN-2:0], in_bit};
    fill_nxt = (fill >= len) ? len : fill + 1'b1;
    // history and pattern bits above the latched length never take part in the compare
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = (fill_nxt == len) && ((hist_nxt & mask) == (pat & mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hist     <= '0;
      pat      <= '0;
      len      <= '0;
      fill     <= '0;
      ovl      <= 1'b0;
      detected <= 1'b0;
      cfg_err  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      detected <= 1'b0;
      cfg_err  <= 1'b0;
      if (cfg_load) begin
        // a load always wins over a data bit, even when the load itself is rejected
        if (cfg_ok) begin
          pat   <= cfg_pattern;
          len   <= cfg_len;
          ovl   <= cfg_overlap;
          hist  <= '0;
          fill  <= '0;
          state <= FILL;
          armed <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (take) begin
        detected <= hit;
        if (hit && !ovl) begin
          hist  <= '0;
          fill  <= '0;
          state <= FILL;
        end else begin
          hist  <= hist_nxt;
          fill  <= fill_nxt;
          state <= (fill_nxt == len) ? RUN : FILL;
        end
      end
    end
  end

`ifdef SEQDET_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      match_count <= '0;
    end else if (cfg_load) begin
      if (cfg_ok) match_count <= '0;
    end else if (take && hit && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: stimulus pushes expected outputs, a monitor pops and compares.
// Build with SEQDET_COUNT_EN defined to also check the saturating match counter.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               detected;
  logic               cfg_err;
  logic               armed;
`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0]   match_count;
`endif

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_bit(in_bit),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .detected(detected),
    .cfg_err(cfg_err),
    .armed(armed)
`ifdef SEQDET_COUNT_EN
    ,
    .match_count(match_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       det;
    logic       err;
    logic       arm;
    logic [1:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] model_cnt = 2'd0;

  // monitor: outputs are registered, so each edge presents one response
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        exp_t e;
        logic [4:0] act;
        logic [4:0] req;
        e = sb.pop_front();
        act = {detected, cfg_err, armed, 2'b00};
        req = {e.det, e.err, e.arm, 2'b00};
`ifdef SEQDET_COUNT_EN
        act[1:0] = match_count;
        req[1:0] = e.cnt;
`endif
        n_cmp++;
        if (act !== req) begin
          n_bad++;
          $display("FAIL %s: got det/err/armed/cnt=%b required %b", e.name, act, req);
        end
      end
    end
  end

  task automatic step(input string name, input logic r, input logic ld,
                      input logic [7:0] pat, input logic [3:0] ln, input logic ov,
                      input logic v, input logic b,
                      input logic edet, input logic eerr, input logic earm);
    exp_t e;
    @(negedge clk);
    rst = r;
    cfg_load = ld;
    cfg_pattern = pat;
    cfg_len = ln;
    cfg_overlap = ov;
    in_valid = v;
    in_bit = b;
    if (r || (ld && ln >= 4'd1 && ln <= 4'd8)) model_cnt = 2'd0;
    else if (edet && model_cnt != 2'd3) model_cnt = model_cnt + 2'd1;
    e.name = name;
    e.det = edet;
    e.err = eerr;
    e.arm = earm;
    e.cnt = model_cnt;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic send(input string name, input logic b, input logic edet);
    step(name, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, edet, 1'b0, 1'b1);
  endtask

  task automatic gap(input string name);
    step(name, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic load(input string name, input logic [7:0] pat, input logic [3:0] ln,
                      input logic ov);
    step(name, 1'b0, 1'b1, pat, ln, ov, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // bits and dets are listed first-sent first (MSB side)
  task automatic send_seq(input string name, input logic [15:0] bits,
                          input logic [15:0] dets, input int n);
    for (int i = 0; i < n; i++) begin
      send(name, bits[n-1-i], dets[n-1-i]);
    end
  endtask

  initial begin
    step("reset", 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle_bit", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("idle_bad_load", 1'b0, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("idle_err_clear", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    load("load_ovl", 8'h0B, 4'd4, 1'b1);
    send_seq("ovl", 16'b1011011, 16'b0001001, 7);

    load("load_novl", 8'h0B, 4'd4, 1'b0);
    send_seq("novl", 16'b1011011, 16'b0001000, 7);

    load("load_gaps", 8'h0B, 4'd4, 1'b1);
    send("gap_b1", 1'b1, 1'b0);
    repeat (3) gap("gap_1");
    send("gap_b2", 1'b0, 1'b0);
    repeat (3) gap("gap_2");
    send("gap_b3", 1'b1, 1'b0);
    repeat (3) gap("gap_3");
    send("gap_b4", 1'b1, 1'b1);
    gap("gap_after");

    step("bad_len0", 1'b0, 1'b1, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    gap("bad_len0_clear");
    step("bad_len9", 1'b0, 1'b1, 8'hFF, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_seq("keep_cfg", 16'b011, 16'b001, 3);

    step("load_prio", 1'b0, 1'b1, 8'h0B, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_seq("prio", 16'b0111011, 16'b0000001, 7);

    load("load_len8", 8'hB2, 4'd8, 1'b0);
    send_seq("len8", 16'b1011001010110010, 16'b0000000100000001, 16);

    load("load_len1", 8'hFD, 4'd1, 1'b1);
    send_seq("len1", 16'b101, 16'b101, 3);

    load("load_pre_rst", 8'h0B, 4'd4, 1'b1);
    send_seq("pre_rst", 16'b101, 16'b000, 3);
    step("mid_rst", 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("post_rst_bit", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    load("reload", 8'h0B, 4'd4, 1'b1);
    send_seq("reload", 16'b1011, 16'b0001, 4);

    load("load_sat", 8'h03, 4'd2, 1'b1);
    send_seq("sat", 16'b111111, 16'b011111, 6);
    gap("sat_hold");

    #5;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter MAX_LEN, default 8, is the maximum pattern length in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default 16, is the match counter width in bits.
REQ-003 Local LEN_W = clog2(MAX_LEN)+1 is the width of cfg_len.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  in_bit is sampled on this edge.
REQ-007 in_bit  input  1  serial data bit.
REQ-008 cfg_load  input  1  load cfg_pattern, cfg_len and cfg_overlap on this edge.
REQ-009 cfg_pattern  input  MAX_LEN  target pattern; bit [len-1] is the first bit received, bit [0] is the last.
REQ-010 cfg_len  input  LEN_W  pattern length.
REQ-011 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 detected  output  1  registered one-cycle match pulse.
REQ-013 cfg_err  output  1  registered one-cycle pulse marking a rejected cfg_load.
REQ-014 armed  output  1  high while the state is FILL or RUN.
REQ-015 match_count  output  CNT_W  saturating match count; present only with SEQDET_COUNT_EN.

Function
REQ-016 The FSM SHALL have states IDLE, FILL and RUN; it enters IDLE on reset.
REQ-017 IDLE: in_valid SHALL be ignored; a legal cfg_load moves the FSM to FILL.
REQ-018 A cfg_load SHALL be legal only if 1 <= cfg_len <= MAX_LEN.
REQ-019 An illegal cfg_load SHALL pulse cfg_err the next cycle and leave state, configuration and history unchanged.
REQ-020 A legal cfg_load SHALL latch the configuration, clear the history register and fill count, and enter FILL.
REQ-021 Each accepted bit SHALL shift into the history register: hist <= {hist[MAX_LEN-2:0], in_bit}.
REQ-022 Each accepted bit SHALL increment the fill count, saturating at the latched length.
REQ-023 FILL SHALL move to RUN on the accepted bit that brings the fill count to the latched length.
REQ-024 A match SHALL occur on the accepted bit for which the fill count reaches or equals the length and hist[len-1:0] equals pattern[len-1:0]; this includes the bit that completes FILL.
REQ-025 detected SHALL be high for exactly the one cycle following the edge that accepted the matching bit.
REQ-026 Overlap mode: after a match the FSM SHALL stay in RUN with the history intact.
REQ-027 Non-overlap mode: a match SHALL clear the history and fill count and return the FSM to FILL.
REQ-028 Cycles with in_valid low SHALL leave history, fill count and state unchanged, and detected SHALL be low.
REQ-029 If cfg_load and in_valid are both high, cfg_load SHALL take priority and the data bit is discarded.
REQ-030 A cfg_load SHALL be accepted in any state, including mid-stream (reconfiguration).
REQ-031 History bits above the latched length SHALL be don't-care for comparison.

Reset
REQ-032 When rst is high: state = IDLE, history = 0, fill count = 0, configuration = 0, detected = 0, cfg_err = 0, armed = 0, match_count = 0.
REQ-033 rst SHALL take priority over cfg_load and in_valid.
REQ-034 A reset mid-stream SHALL require a new cfg_load before any further detection.

Configuration
REQ-035 With SEQDET_COUNT_EN defined: match_count SHALL increment on every detected pulse, hold at 2^CNT_W-1, and clear on reset and on a legal cfg_load.
REQ-036 Without SEQDET_COUNT_EN: the match_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Load 1011, len 4, overlap 1; stream 1,0,1,1,0,1,1 -> detected after bits 4 and 7.
REQ-038 Same load and stream with overlap 0 -> detected after bit 4 only.
REQ-039 Load 1011, len 4; send 1,0 with in_valid low for 3 cycles between bits, then 1,1 -> one detected pulse, none during the gaps.
REQ-040 cfg_len = 0 and cfg_len = MAX_LEN+1 -> cfg_err pulses; armed and the prior configuration are unchanged.
REQ-041 Apply rst after 1,0,1, then send 1 -> no detected, armed = 0; after a reload, 1,0,1,1 -> detected.
REQ-042 With SEQDET_COUNT_EN and CNT_W = 2: load 11, len 2, overlap 1; send six 1s -> match_count reaches 3 and holds.
